// File: rtl/expipe_pkg.sv
// rtl/expipe_pkg.sv - execution pipeline widths and the shared CDB payload type
package expipe_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_IDX_LEN    = 4;
  localparam int ROB_EXCEPT_LEN = 4;

  // Payload carried on the common data bus; RS, ROB and the arbiter slot agree on this layout.
  typedef struct packed {
    logic [ROB_IDX_LEN-1:0]    rob_idx;
    logic [XLEN-1:0]           data;
    logic                      except_raised;
    logic [ROB_EXCEPT_LEN-1:0] except_code;
  } cdb_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a priority pointer
//
// Ports:
//   i_req    requests, one bit per source
//   i_ptr    highest-priority source this cycle
//   o_grant  one-hot grant (all zero when nothing requests)
//   o_idx    index of the granted source (0 when nothing requests)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic w_found;
  int   w_k;

  // Scan N sources starting at the pointer; the first requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int off = 0; off < N; off++) begin
      w_k = (int'(i_ptr) + off) % N;
      if (!w_found && i_req[w_k]) begin
        w_found      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = IW'(w_k);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin collector of RS results into a one-entry CDB broadcast slot
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 pipeline flush: drops the slot, blocks acceptance
//   rs_valid_i/rs_ready_o   per-source handshake with the reservation stations
//   rs_idx_i, rs_data_i,
//   rs_except_raised_i,
//   rs_except_i             per-source result fields, packed source 0 in the LSBs
//   rob_ready_i             ROB consumes the current broadcast
//   cdb_*_o                 registered broadcast to the ROB and every RS
module cdb_arbiter
  import expipe_pkg::*;
#(
  parameter int N_EU           = 4,
  parameter int XLEN           = expipe_pkg::XLEN,
  parameter int ROB_IDX_LEN    = expipe_pkg::ROB_IDX_LEN,
  parameter int ROB_EXCEPT_LEN = expipe_pkg::ROB_EXCEPT_LEN
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [N_EU-1:0]                rs_valid_i,
  output logic [N_EU-1:0]                rs_ready_o,
  input  logic [N_EU*ROB_IDX_LEN-1:0]    rs_idx_i,
  input  logic [N_EU*XLEN-1:0]           rs_data_i,
  input  logic [N_EU-1:0]                rs_except_raised_i,
  input  logic [N_EU*ROB_EXCEPT_LEN-1:0] rs_except_i,
  input  logic                           rob_ready_i,
  output logic                           cdb_valid_o,
  output logic [ROB_IDX_LEN-1:0]         cdb_idx_o,
  output logic [XLEN-1:0]                cdb_data_o,
  output logic                           cdb_except_raised_o,
  output logic [ROB_EXCEPT_LEN-1:0]      cdb_except_o
);

  localparam int IW = $clog2(N_EU);

  logic [IW-1:0]             r_ptr;
  logic                      r_valid;
  logic [ROB_IDX_LEN-1:0]    r_idx;
  logic [XLEN-1:0]           r_data;
  logic                      r_except_raised;
  logic [ROB_EXCEPT_LEN-1:0] r_except;

  logic [N_EU-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_can_load;
  logic            w_xfer;

  rr_arbiter #(.N(N_EU), .IW(IW)) u_rr (
    .i_req   (rs_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  // The slot can take a new result when it is empty or being drained this cycle.
  assign w_can_load = ~r_valid | rob_ready_i;
  assign rs_ready_o = w_grant & {N_EU{w_can_load & ~flush_i & ~rst_i}};
  assign w_xfer     = |rs_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr           <= '0;
      r_valid         <= 1'b0;
      r_idx           <= '0;
      r_data          <= '0;
      r_except_raised <= 1'b0;
      r_except        <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid         <= 1'b1;
      r_idx           <= rs_idx_i[int'(w_gidx)*ROB_IDX_LEN +: ROB_IDX_LEN];
      r_data          <= rs_data_i[int'(w_gidx)*XLEN +: XLEN];
      r_except_raised <= rs_except_raised_i[w_gidx];
      r_except        <= rs_except_i[int'(w_gidx)*ROB_EXCEPT_LEN +: ROB_EXCEPT_LEN];
      // Winner drops to lowest priority next cycle.
      r_ptr           <= (w_gidx == IW'(N_EU - 1)) ? '0 : w_gidx + 1'b1;
    end else if (rob_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign cdb_valid_o         = r_valid;
  assign cdb_idx_o           = r_idx;
  assign cdb_data_o          = r_data;
  assign cdb_except_raised_o = r_except_raised;
  assign cdb_except_o        = r_except;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int IL = 4;
  localparam int EL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*IL-1:0] idx;
  logic [N*XL-1:0] data;
  logic [N-1:0]    er;
  logic [N*EL-1:0] ec;
  logic            rob_ready;
  logic            cdb_valid;
  logic [IL-1:0]   cdb_idx;
  logic [XL-1:0]   cdb_data;
  logic            cdb_er;
  logic [EL-1:0]   cdb_ec;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_EU(N), .XLEN(XL), .ROB_IDX_LEN(IL), .ROB_EXCEPT_LEN(EL)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .rs_valid_i          (valid),
    .rs_ready_o          (ready),
    .rs_idx_i            (idx),
    .rs_data_i           (data),
    .rs_except_raised_i  (er),
    .rs_except_i         (ec),
    .rob_ready_i         (rob_ready),
    .cdb_valid_o         (cdb_valid),
    .cdb_idx_o           (cdb_idx),
    .cdb_data_o          (cdb_data),
    .cdb_except_raised_o (cdb_er),
    .cdb_except_o        (cdb_ec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; inputs are then changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int k, input logic [IL-1:0] i, input logic [XL-1:0] d,
                         input logic e, input logic [EL-1:0] c);
    idx[k*IL +: IL] = i;
    data[k*XL +: XL] = d;
    er[k]            = e;
    ec[k*EL +: EL]   = c;
  endtask

  task automatic chk_bcast(input string tag, input logic [IL-1:0] i, input logic [XL-1:0] d,
                           input logic e, input logic [EL-1:0] c);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, ".idx"},   64'(cdb_idx),   64'(i));
    chk({tag, ".data"},  64'(cdb_data),  64'(d));
    chk({tag, ".er"},    64'(cdb_er),    64'(e));
    chk({tag, ".ec"},    64'(cdb_ec),    64'(c));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = '0; rob_ready = 1'b1;
    idx = '0; data = '0; er = '0; ec = '0;

    // 1 reset with every source requesting
    valid = 4'b1111;
    step();
    chk("rst.ready0", 64'(ready), 64'd0);
    chk("rst.valid0", 64'(cdb_valid), 64'd0);
    step();
    chk("rst.ready1", 64'(ready), 64'd0);
    chk("rst.valid1", 64'(cdb_valid), 64'd0);
    chk("rst.idx", 64'(cdb_idx), 64'd0);
    chk("rst.data", 64'(cdb_data), 64'd0);
    rst = 1'b0;
    settle();
    chk("rst.first_grant", 64'(ready), 64'b0001);
    valid = '0;
    settle();
    chk("idle.ready", 64'(ready), 64'd0);
    step();
    chk("idle.valid", 64'(cdb_valid), 64'd0);

    // 2 single source 2
    set_src(2, 4'd5, 32'hDEAD, 1'b0, 4'd0);
    valid = 4'b0100;
    settle();
    chk("single.ready", 64'(ready), 64'b0100);
    step();
    valid = '0;
    chk_bcast("single", 4'd5, 32'hDEAD, 1'b0, 4'd0);
    settle();
    chk("single.ready_after", 64'(ready), 64'd0);
    step();
    chk("single.drain", 64'(cdb_valid), 64'd0);

    // 3 fairness from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.valid", 64'(cdb_valid), 64'd0);
    for (int k = 0; k < N; k++) set_src(k, IL'(k + 1), XL'(32'h100 + k), 1'b0, 4'd0);
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("fair.grant%0d", i), 64'(ready), 64'(4'b0001 << (i % N)));
      step();
      chk_bcast($sformatf("fair.bc%0d", i), IL'((i % N) + 1), XL'(32'h100 + (i % N)), 1'b0, 4'd0);
    end

    // 4 ROB stall holding src0's result; pointer now at 1
    rob_ready = 1'b0;
    settle();
    chk("stall.ready", 64'(ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bcast($sformatf("stall%0d", i), 4'd1, 32'h100, 1'b0, 4'd0);
      chk($sformatf("stall%0d.ready", i), 64'(ready), 64'd0);
    end
    rob_ready = 1'b1;
    settle();
    chk("unstall.ready", 64'(ready), 64'b0010);
    step();
    chk_bcast("unstall", 4'd2, 32'h101, 1'b0, 4'd0);

    // 5 flush while FULL; pointer stays at 2
    valid = 4'b0010;
    flush = 1'b1;
    settle();
    chk("flush.ready", 64'(ready), 64'd0);
    step();
    flush = 1'b0;
    chk("flush.valid", 64'(cdb_valid), 64'd0);
    valid = 4'b0110;
    settle();
    chk("flush.ptr", 64'(ready), 64'b0100);

    // 6 move pointer to 3, then wrap with exception on src3
    step();
    valid = '0;
    chk_bcast("toptr3", 4'd3, 32'h102, 1'b0, 4'd0);
    step();
    chk("toptr3.drain", 64'(cdb_valid), 64'd0);
    set_src(3, 4'd9, 32'h3333, 1'b1, 4'd2);
    set_src(0, 4'd7, 32'h0A0A, 1'b0, 4'd0);
    valid = 4'b1001;
    settle();
    chk("wrap.grant3", 64'(ready), 64'b1000);
    step();
    valid = 4'b0001;
    chk_bcast("wrap.src3", 4'd9, 32'h3333, 1'b1, 4'd2);
    settle();
    chk("wrap.grant0", 64'(ready), 64'b0001);
    step();
    valid = '0;
    chk_bcast("wrap.src0", 4'd7, 32'h0A0A, 1'b0, 4'd0);
    step();
    chk("wrap.drain", 64'(cdb_valid), 64'd0);

    // reset mid-broadcast drops the pending result
    set_src(1, 4'd4, 32'h4444, 1'b0, 4'd0);
    valid = 4'b0010;
    step();
    valid = '0;
    chk("midrst.loaded", 64'(cdb_valid), 64'd1);
    rob_ready = 1'b0;
    rst = 1'b1;
    flush = 1'b1;
    step();
    chk("midrst.valid", 64'(cdb_valid), 64'd0);
    chk("midrst.data", 64'(cdb_data), 64'd0);
    rst = 1'b0;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
